// File: rtl/fp_adder_pkg.sv
// Shared state encoding and default-width constants for the fp_adder_ctrl slice.
// Optional feature macro: FP_ADD_SPECIAL_EN (adds the SPECIAL state for inf/NaN operands).
package fp_adder_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
`ifdef FP_ADD_SPECIAL_EN
    ,
    SPECIAL
`endif
  } fp_state_e;

endpackage

// File: rtl/fp_adder_ctrl_align.sv
// fp_align_shift: saturating logarithmic right shifter for the smaller significand.
// Shift amounts of W or more return zero.
module fp_align_shift #(
  parameter int W   = 24,
  parameter int SHW = 8
) (
  input  logic [W-1:0]   data_i,
  input  logic [SHW-1:0] shamt_i,
  output logic [W-1:0]   data_o
);

  localparam int LOG = $clog2(W);

  logic [W-1:0] stage [LOG+1];

  assign stage[0] = data_i;

  genvar gi;
  generate
    for (gi = 0; gi < LOG; gi++) begin : g_stage
      if (gi < SHW) begin : g_used
        assign stage[gi+1] = shamt_i[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
      end else begin : g_pass
        assign stage[gi+1] = stage[gi];
      end
    end
  endgenerate

  assign data_o = (32'(shamt_i) >= W) ? '0 : stage[LOG];

endmodule

// File: rtl/fp_adder_ctrl.sv
// Multi-cycle truncating floating-point adder: IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Optional macro FP_ADD_SPECIAL_EN routes inf/NaN operands through a short SPECIAL path.
module fp_adder_ctrl
  import fp_adder_pkg::*;
#(
  parameter int FP_SIZE   = 1 + EXP_W + FRAC_W,
  parameter int FRAC_SIZE = FRAC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FP_SIZE-1:0] num_a,
  input  logic [FP_SIZE-1:0] num_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FP_SIZE-1:0] result,
  output logic               overflow,
  output logic               busy
);

  localparam int EW = FP_SIZE - FRAC_SIZE - 1;
  localparam int SW = FRAC_SIZE + 1;
  localparam logic [EW:0] EXP_MAX = {1'b0, {EW{1'b1}}};
  localparam logic [EW:0] EXP_ONE = {{EW{1'b0}}, 1'b1};

  fp_state_e state_q, state_d;

  logic [FP_SIZE-1:0] a_q, a_d, b_q, b_d;
  logic [FP_SIZE-1:0] result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               sign_q, sign_d, sub_q, sub_d;
  logic [EW:0]        exp_q, exp_d;
  logic [SW-1:0]      sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic [SW:0]        sum_q, sum_d;

  logic [EW-1:0] ea, eb, big_exp, small_exp, shamt;
  logic [SW-1:0] sa, sb, big_sig, small_sig, small_shifted;
  logic          a_ge_b, big_sign;
  logic [EW:0]   exp_inc, exp_dec;

  // Zero-exponent operands are flushed to zero: no hidden bit, no fraction.
  assign ea = a_q[FP_SIZE-2:FRAC_SIZE];
  assign eb = b_q[FP_SIZE-2:FRAC_SIZE];
  assign sa = (ea != '0) ? {1'b1, a_q[FRAC_SIZE-1:0]} : '0;
  assign sb = (eb != '0) ? {1'b1, b_q[FRAC_SIZE-1:0]} : '0;

  assign a_ge_b    = {ea, sa} >= {eb, sb};
  assign big_exp   = a_ge_b ? ea : eb;
  assign small_exp = a_ge_b ? eb : ea;
  assign big_sig   = a_ge_b ? sa : sb;
  assign small_sig = a_ge_b ? sb : sa;
  assign big_sign  = a_ge_b ? a_q[FP_SIZE-1] : b_q[FP_SIZE-1];
  assign shamt     = big_exp - small_exp;

  assign exp_inc = exp_q + 1'b1;
  assign exp_dec = exp_q - 1'b1;

  fp_align_shift #(
    .W   (SW),
    .SHW (EW)
  ) u_align_shift (
    .data_i  (small_sig),
    .shamt_i (shamt),
    .data_o  (small_shifted)
  );

  // Returns {overflow, packed}; an unnormalised significand can only survive at exponent 1.
  function automatic logic [FP_SIZE:0] pack(input logic s, input logic [EW:0] e,
                                            input logic [SW-1:0] m);
    logic [FP_SIZE:0] r;
    if (e >= EXP_MAX) begin
      r = {1'b1, s, {EW{1'b1}}, {FRAC_SIZE{1'b0}}};
    end else begin
      r = {1'b0, s, (m[SW-1] ? e[EW-1:0] : {EW{1'b0}}), m[FRAC_SIZE-1:0]};
    end
    return r;
  endfunction

`ifdef FP_ADD_SPECIAL_EN
  localparam logic [FP_SIZE-1:0] QNAN_V = {1'b0, {EW{1'b1}}, 1'b1, {(FRAC_SIZE-1){1'b0}}};

  logic               in_special, a_nan, b_nan, a_inf, b_inf;
  logic [FP_SIZE-1:0] special_res;

  assign in_special = (&num_a[FP_SIZE-2:FRAC_SIZE]) || (&num_b[FP_SIZE-2:FRAC_SIZE]);
  assign a_nan = (&ea) && (a_q[FRAC_SIZE-1:0] != '0);
  assign b_nan = (&eb) && (b_q[FRAC_SIZE-1:0] != '0);
  assign a_inf = (&ea) && (a_q[FRAC_SIZE-1:0] == '0);
  assign b_inf = (&eb) && (b_q[FRAC_SIZE-1:0] == '0);
  assign special_res = (a_nan || b_nan || (a_inf && b_inf && (a_q[FP_SIZE-1] != b_q[FP_SIZE-1])))
                     ? QNAN_V : (a_inf ? a_q : b_q);
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    exp_d      = exp_q;
    sig_a_d    = sig_a_q;
    sig_b_d    = sig_b_q;
    sum_d      = sum_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = num_a;
          b_d     = num_b;
          state_d = ALIGN;
`ifdef FP_ADD_SPECIAL_EN
          if (in_special) state_d = SPECIAL;
`endif
        end
      end
      ALIGN: begin
        sign_d  = big_sign;
        sub_d   = a_q[FP_SIZE-1] ^ b_q[FP_SIZE-1];
        exp_d   = {1'b0, big_exp};
        sig_a_d = big_sig;
        sig_b_d = small_shifted;
        state_d = ADD;
      end
      ADD: begin
        sum_d   = sub_q ? ({1'b0, sig_a_q} - {1'b0, sig_b_q})
                        : ({1'b0, sig_a_q} + {1'b0, sig_b_q});
        state_d = NORM;
      end
      NORM: begin
        state_d = DONE;
        if (sum_q == '0) begin
          result_d   = '0;
          overflow_d = 1'b0;
        end else if (sum_q[SW]) begin
          sum_d                  = sum_q >> 1;
          exp_d                  = exp_inc;
          {overflow_d, result_d} = pack(sign_q, exp_inc, sum_q[SW:1]);
        end else if (sum_q[SW-1] || (exp_q == EXP_ONE)) begin
          {overflow_d, result_d} = pack(sign_q, exp_q, sum_q[SW-1:0]);
        end else begin
          sum_d   = sum_q << 1;
          exp_d   = exp_dec;
          state_d = NORM;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
`ifdef FP_ADD_SPECIAL_EN
      SPECIAL: begin
        result_d   = special_res;
        overflow_d = 1'b0;
        state_d    = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      exp_q      <= '0;
      sig_a_q    <= '0;
      sig_b_q    <= '0;
      sum_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      exp_q      <= exp_d;
      sig_a_q    <= sig_a_d;
      sig_b_q    <= sig_b_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/fp_adder_ctrl.md
FP_ADDER_CTRL -- requirements
Module: fp_adder_ctrl

Interface
REQ-001 Parameter FP_SIZE, default 32, total floating-point width.
REQ-002 Parameter FRAC_SIZE, default 23, stored fraction width; exponent width EXP_W = FP_SIZE-FRAC_SIZE-1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair present on num_a/num_b.
REQ-006 in_ready  output  1  controller accepts operands this cycle.
REQ-007 num_a, num_b  input  FP_SIZE each  IEEE-754 operands.
REQ-008 out_valid  output  1  result holds a completed sum.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 result  output  FP_SIZE  packed sum.
REQ-011 overflow  output  1  sum exceeded the largest finite value; qualified by out_valid.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, ALIGN, ADD, NORM, DONE, plus SPECIAL when FP_ADD_SPECIAL_EN is defined.
REQ-014 in_ready SHALL equal (state==IDLE); accept = in_valid && in_ready registers both operands; IDLE->ALIGN.
REQ-015 Unpack: hidden bit = 1 when exponent != 0; exponent 0 operands flushed to zero (denormals unsupported).
REQ-016 ALIGN (1 cycle): order operands by {exponent, significand} so A magnitude >= B; right-shift B significand by eA-eB; shifts >= FRAC_SIZE+1 give 0; result sign = sign of A; ALIGN->ADD.
REQ-017 ADD (1 cycle): same signs -> FRAC_SIZE+2-bit sum with carry; differing signs -> A-B, never negative; ADD->NORM.
REQ-018 NORM on carry: shift right 1 and exponent+1 in one cycle, then ->DONE.
REQ-019 NORM without carry: one left shift and exponent-1 per cycle until MSB=1 or exponent=1, then ->DONE; a zero significand goes to DONE immediately.
REQ-020 Discarded bits SHALL be truncated; no rounding.
REQ-021 Zero significand SHALL yield result +0 (0x00000000 at default width).
REQ-022 A result exponent >= 2^EXP_W-1 SHALL yield signed infinity with overflow=1.
REQ-023 Latency from the accept edge to out_valid SHALL be 4 cycles plus one per extra left shift; maximum 4+FRAC_SIZE.
REQ-024 DONE: out_valid=1 with result/overflow stable until out_ready; on handshake ->IDLE; in_ready rises the next cycle (no same-cycle re-accept).
REQ-025 in_valid while busy SHALL be ignored; operands are not captured.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, out_valid=0, result=0, overflow=0, busy=0, in_ready=1 at any point, mid-operation included.
REQ-027 After rst_n deasserts, the first accept SHALL be possible on the first clock edge.

Configuration
REQ-028 Macro FP_ADD_SPECIAL_EN defined: an operand with all-ones exponent goes IDLE->SPECIAL->DONE, so out_valid follows the accept edge by 2 cycles. Outputs: NaN in or inf+(-inf) -> quiet NaN 0x7FC00000; inf plus anything else -> that inf; overflow=0.
REQ-029 Macro undefined: no special detection; all-ones exponents follow the normal path and REQ-022 applies.

Structure
REQ-030 Shared package fp_adder_pkg SHALL hold the state enum, EXP_W, and the QNAN and INF constants.
REQ-031 Sub-module fp_align_shift SHALL implement the saturating right barrel shifter used in ALIGN.

Verification
REQ-032 0x3F800000+0x3F800000 -> 0x40000000, out_valid 4 cycles after accept, overflow=0.
REQ-033 0x3FC00000+0xBF800000 -> 0x3F000000 after 5 cycles (one left shift); 0x3F800000+0xBF800000 -> 0x00000000.
REQ-034 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow=1.
REQ-035 out_ready held low 3 cycles in DONE: result stable, in_ready=0, new in_valid ignored; handshake -> IDLE.
REQ-036 rst_n pulsed low during NORM -> outputs at reset values at once; next operand pair computes correctly.
REQ-037 FP_ADD_SPECIAL_EN: 0x7F800000+0xFF800000 -> 0x7FC00000 and 0x7F800000+0x3F800000 -> 0x7F800000, out_valid 2 cycles after accept.
